data_mem_lat: RTL and testbench



---
 rtl/data_mem_lat.sv | 146 ++++++++++++++
 tb/tb_data_mem_lat.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/data_mem_lat.sv
// rtl/data_mem_lat.sv - multi-cycle data memory with a fixed-latency busy_wait stall.
// Optional: define DATA_MEM_CLEAR_EN to zero the whole array after every reset release.
module data_mem_lat #(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int LATENCY = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] read_data,
  output logic              busy_wait,
  output logic              req_err
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int CNT_W = $clog2(LATENCY + 1);

  if (LATENCY < 1 || LATENCY > 255) begin : g_bad_latency
    $error("data_mem_lat: LATENCY must be in 1..255");
  end

`ifdef DATA_MEM_CLEAR_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE, CLEAR} state_t;
  localparam state_t RESET_STATE = CLEAR;
`else
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
  localparam state_t RESET_STATE = IDLE;
`endif

  state_t            state, state_next;
  logic              op_read;
  logic [ADDR_W-1:0] op_addr;
  logic [DATA_W-1:0] op_data;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] mem [DEPTH];

  logic              request, accept, commit, busy_raw;
  logic              commit_rd;
  logic [ADDR_W-1:0] commit_addr;
  logic [DATA_W-1:0] commit_data;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
`ifdef DATA_MEM_CLEAR_EN
  logic [ADDR_W-1:0] clr_addr;
`endif

  assign request   = read ^ write;
  assign busy_wait = rst & busy_raw;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RESET_STATE;
    else      state <= state_next;
  end

  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    commit      = 1'b0;
    busy_raw    = 1'b0;
    commit_rd   = op_read;
    commit_addr = op_addr;
    commit_data = op_data;
    mem_we      = 1'b0;
    mem_waddr   = op_addr;
    mem_wdata   = op_data;
    case (state)
      IDLE: begin
        busy_raw = request;
        if (request) begin
          accept = 1'b1;
          // With single-cycle latency nothing is latched yet, so commit from the live inputs
          commit_rd   = read;
          commit_addr = address;
          commit_data = write_data;
          if (LATENCY == 1) begin
            commit     = 1'b1;
            state_next = DONE;
          end else begin
            state_next = BUSY;
          end
        end
      end
      BUSY: begin
        busy_raw = 1'b1;
        if (count == CNT_W'(1)) begin
          commit     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: state_next = IDLE;
`ifdef DATA_MEM_CLEAR_EN
      CLEAR: begin
        busy_raw  = 1'b1;
        mem_we    = rst;
        mem_waddr = clr_addr;
        mem_wdata = '0;
        if (clr_addr == ADDR_W'(DEPTH - 1)) state_next = DONE;
      end
`endif
      default: state_next = IDLE;
    endcase
    if (commit && !commit_rd) begin
      mem_we    = rst;
      mem_waddr = commit_addr;
      mem_wdata = commit_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      op_read   <= 1'b0;
      op_addr   <= '0;
      op_data   <= '0;
      count     <= '0;
      read_data <= '0;
      req_err   <= 1'b0;
    end else begin
      req_err <= (state == IDLE) && read && write;
      if (accept) begin
        op_read <= read;
        op_addr <= address;
        op_data <= write_data;
        count   <= CNT_W'(LATENCY - 1);
      end else if (state == BUSY) begin
        count <= count - CNT_W'(1);
      end
      if (commit && commit_rd) read_data <= mem[commit_addr];
    end
  end

`ifdef DATA_MEM_CLEAR_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                clr_addr <= '0;
    else if (state == CLEAR) clr_addr <= clr_addr + 1'b1;
  end
`endif

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

endmodule

// File: tb/tb_data_mem_lat.sv
// tb/tb_data_mem_lat.sv - scoreboard bench for data_mem_lat with directed and random accesses.
module tb_data_mem_lat;
  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int LAT    = 4;
  localparam int DEPTH  = 256;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              read = 1'b0;
  logic              write = 1'b0;
  logic [ADDR_W-1:0] address = '0;
  logic [DATA_W-1:0] write_data = '0;
  logic [DATA_W-1:0] read_data;
  logic              busy_wait;
  logic              req_err;

  always #5 clk = ~clk;

  data_mem_lat #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .read(read), .write(write), .address(address),
    .write_data(write_data), .read_data(read_data), .busy_wait(busy_wait), .req_err(req_err)
  );

  typedef struct {
    int         len;
    bit         chk;
    logic [7:0] data;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  logic [7:0] ref_mem [DEPTH];
  bit         known [DEPTH];
  logic [7:0] last_rd;
  bit         last_known;
  int         pass_cnt = 0;
  int         total_cnt = 0;
  int         bcnt = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got %0h, required %0h", name, act, exp);
    else pass_cnt++;
  endtask

  task automatic push_exp(int len, bit chk, logic [7:0] d);
    exp_t e;
    e.len = len; e.chk = chk; e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic wait_busy_low(string name);
    int n;
    n = 0;
    do begin
      @(posedge clk); #1;
      n++;
    end while (busy_wait === 1'b1 && n < 2000);
    if (busy_wait !== 1'b0) begin
      total_cnt++;
      $display("FAIL %s_timeout: busy_wait=%b after %0d cycles, required 0", name, busy_wait, n);
    end
  endtask

  // CPU-like access: request held through the stall and the DONE cycle, dropped in IDLE
  task automatic access(bit is_rd, logic [7:0] a, logic [7:0] d);
    if (is_rd) begin
      push_exp(LAT, known[a], ref_mem[a]);
      last_rd = ref_mem[a];
      last_known = known[a];
    end else begin
      push_exp(LAT, last_known, last_rd);
      ref_mem[a] = d;
      known[a] = 1'b1;
    end
    read = is_rd; write = !is_rd; address = a; write_data = d;
    wait_busy_low("access");
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic release_reset();
`ifdef DATA_MEM_CLEAR_EN
    push_exp(DEPTH, 1'b1, 8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      ref_mem[i] = 8'h00;
      known[i] = 1'b1;
    end
`endif
    rst = 1'b1;
`ifdef DATA_MEM_CLEAR_EN
    wait_busy_low("clear");
    @(posedge clk); #1;
`endif
  endtask

  always @(negedge clk) begin
    if (rst !== 1'b1) begin
      bcnt = 0;
    end else if (busy_wait === 1'b1) begin
      bcnt++;
    end else if (bcnt > 0) begin
      if (exp_q.size() == 0) begin
        total_cnt++;
        $display("FAIL unexpected_access: busy period of %0d cycles, required none", bcnt);
      end else begin
        mon_e = exp_q.pop_front();
        check("busy_len", bcnt, mon_e.len);
        if (mon_e.chk) check("read_data", read_data, mon_e.data);
      end
      bcnt = 0;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit         rd;
    logic [7:0] a;
    logic [7:0] d;
    rst = 1'b0; read = 1'b1; write = 1'b0; address = 8'h00;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy_wait", busy_wait, 0);
    check("rst_read_data", read_data, 0);
    check("rst_req_err", req_err, 0);
    read = 1'b0;
    last_rd = 8'h00; last_known = 1'b1;
    release_reset();

    access(1'b0, 8'h00, 8'h11);
    access(1'b1, 8'h00, 8'h00);
    access(1'b0, 8'h05, 8'h5A);

    read = 1'b1; write = 1'b1; address = 8'h05; write_data = 8'hAA;
    #1;
    check("err_busy_wait", busy_wait, 0);
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
    check("req_err_pulse", req_err, 1);
    @(posedge clk); #1;
    check("req_err_clear", req_err, 0);
    access(1'b1, 8'h05, 8'h00);

    access(1'b0, 8'hFF, 8'h55);
    access(1'b1, 8'hFF, 8'h00);
    access(1'b0, 8'h07, 8'h81);
    access(1'b1, 8'h07, 8'h00);

    read = 1'b0; write = 1'b1; address = 8'h07; write_data = 8'h3C;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b0; write = 1'b0;
    #1;
    check("midrst_busy_wait", busy_wait, 0);
    check("midrst_read_data", read_data, 0);
    last_rd = 8'h00; last_known = 1'b1;
    repeat (2) begin
      @(posedge clk); #1;
    end
    release_reset();
    access(1'b1, 8'h07, 8'h00);
    access(1'b1, 8'hFF, 8'h00);

    for (int i = 0; i < 40; i++) begin
      rd = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) == 0) a = 8'($urandom);
      else a = 8'($urandom_range(0, 15));
      d = 8'($urandom);
      access(rd, a, d);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
